// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream
//   2x2 / stride-2 max pooling over a raster-ordered square feature map coming
//   from the 3x3 convolution stage. Column pairs are reduced as they arrive.
//   On even rows the pair maximum is parked in a half-width line buffer. On odd
//   rows it is merged with the parked value to form the pooled result.
//
// Ports
//   sys_clk         clock, rising edge
//   sys_rst         asynchronous active-high reset
//   map_size        feature-map width (= height), latched at frame start
//   pi_data         signed input sample
//   pi_data_valid   input sample qualifier (gaps allowed)
//   pi_frame_valid  high while a frame streams; a fall mid-frame aborts it
//   po_data         signed pooled maximum (holds when not valid)
//   po_data_valid   one-cycle qualifier per pooled sample
//   po_frame_done   one-cycle pulse one clock after the last frame sample
//
// state  | meaning
// S_IDLE | waiting for the first accepted sample of a frame
// S_RUN  | streaming; row/col track the position of the next sample
// S_DONE | frame complete; done pulse is visible, inputs are dropped
module maxpool_2x2_stream #(
  parameter int MAX_W = 256,
  parameter int DW    = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [8:0]           map_size,
  input  logic signed [DW-1:0] pi_data,
  input  logic                 pi_data_valid,
  input  logic                 pi_frame_valid,
  output logic signed [DW-1:0] po_data,
  output logic                 po_data_valid,
  output logic                 po_frame_done
);

  localparam int LB_D = MAX_W / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [8:0]           w_q;
  logic [8:0]           row_q;
  logic [8:0]           col_q;
  logic signed [DW-1:0] pair_q;
  logic signed [DW-1:0] linebuf [LB_D];

  logic                 accept;
  logic                 start_ok;
  logic                 proc;
  logic                 last;
  logic [8:0]           row_cur;
  logic [8:0]           col_cur;
  logic [AW-1:0]        lb_addr;
  logic signed [DW-1:0] lb_rd;
  logic signed [DW-1:0] pm;
  logic signed [DW-1:0] pool_max;

  always_comb begin
    accept   = pi_data_valid & pi_frame_valid;
    start_ok = (map_size >= 9'd2);
    // The first sample of a frame is consumed in IDLE as position (0,0).
    proc     = accept & (((state_q == S_IDLE) & start_ok) | (state_q == S_RUN));
    row_cur  = (state_q == S_RUN) ? row_q : 9'd0;
    col_cur  = (state_q == S_RUN) ? col_q : 9'd0;
    lb_addr  = AW'(col_cur >> 1);
    lb_rd    = linebuf[lb_addr];
    pm       = (pair_q > pi_data) ? pair_q : pi_data;
    pool_max = (pm > lb_rd) ? pm : lb_rd;
    last     = (row_q == w_q - 9'd1) && (col_q == w_q - 9'd1);
  end

  // Line buffer carries no reset; every entry read on an odd row was written
  // on the even row just above it within the same frame.
  always_ff @(posedge sys_clk) begin
    if (proc && col_cur[0] && !row_cur[0]) begin
      linebuf[lb_addr] <= pm;
    end
  end

  // Odd widths need no special casing: the trailing column and row sit at
  // even positions, so they only ever load pair_q / linebuf and never emit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      w_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pair_q        <= '0;
      po_data       <= '0;
      po_data_valid <= 1'b0;
      po_frame_done <= 1'b0;
    end else begin
      po_data_valid <= 1'b0;
      po_frame_done <= 1'b0;

      if (proc && !col_cur[0]) begin
        pair_q <= pi_data;
      end
      if (proc && col_cur[0] && row_cur[0]) begin
        po_data       <= pool_max;
        po_data_valid <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept && start_ok) begin
            w_q     <= map_size;
            row_q   <= '0;
            col_q   <= 9'd1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!pi_frame_valid) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_IDLE;
          end else if (accept) begin
            if (last) begin
              po_frame_done <= 1'b1;
              state_q       <= S_DONE;
            end else if (col_q == w_q - 9'd1) begin
              col_q <= '0;
              row_q <= row_q + 9'd1;
            end else begin
              col_q <= col_q + 9'd1;
            end
          end
        end
        S_DONE: begin
          row_q   <= '0;
          col_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
module tb_maxpool_2x2_stream;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [8:0]         map_size;
  logic signed [15:0] pi_data;
  logic               pi_data_valid;
  logic               pi_frame_valid;
  logic signed [15:0] po_data;
  logic               po_data_valid;
  logic               po_frame_done;

  maxpool_2x2_stream #(.MAX_W(256), .DW(16)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .map_size       (map_size),
    .pi_data        (pi_data),
    .pi_data_valid  (pi_data_valid),
    .pi_frame_valid (pi_frame_valid),
    .po_data        (po_data),
    .po_data_valid  (po_data_valid),
    .po_frame_done  (po_frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  exp_t e;
  int   dc;

  int d_err = 0, d_chk = 0;
  int m_err = 0, m_chk = 0;

  int vals [0:4095];
  int mw;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (po_data_valid) begin
        m_chk++;
        if (exp_q.size() == 0) begin
          m_err++;
          $display("FAIL unexpected_output: got data=%0d at cycle %0d, expected no output", po_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (int'(po_data) != e.data || cyc != e.cyc) begin
            m_err++;
            $display("FAIL po_data: got %0d at cycle %0d, expected %0d at cycle %0d",
                     po_data, cyc, e.data, e.cyc);
          end
        end
      end
      if (po_frame_done) begin
        m_chk++;
        if (done_q.size() == 0) begin
          m_err++;
          $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          dc = done_q.pop_front();
          if (cyc != dc) begin
            m_err++;
            $display("FAIL po_frame_done: got pulse at cycle %0d, expected cycle %0d", cyc, dc);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    d_chk++;
    if (act != exp) begin
      d_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic send(input logic signed [15:0] d, input logic v, input logic fv);
    @(posedge sys_clk);
    #1;
    pi_data        = d;
    pi_data_valid  = v;
    pi_frame_valid = fv;
  endtask

  // Reference: sample idx sits at (idx / w, idx % w). Each 2x2 window inside
  // the floor(w/2)*2 square completes at its bottom-right sample, whose
  // acceptance edge is the next posedge; the result shows in that cycle.
  task automatic model_accept(input int idx);
    int r, c, lim;
    exp_t x;
    r   = idx / mw;
    c   = idx % mw;
    lim = (mw / 2) * 2;
    if ((r % 2 == 1) && (c % 2 == 1) && r < lim && c < lim) begin
      x.data = max4(vals[(r-1)*mw + c-1], vals[(r-1)*mw + c],
                    vals[r*mw + c-1],     vals[r*mw + c]);
      x.cyc  = cyc + 1;
      exp_q.push_back(x);
    end
    if (mw >= 2 && idx == mw * mw - 1) begin
      done_q.push_back(cyc + 1);
    end
  endtask

  // kind: 0 = 1..w*w, 1 = random, 2 = {-5,-1,-3,-7}
  // gap:  0 = none, 1 = one idle cycle after each sample, 2 = random 0..2
  // stop_at: drop the frame before this sample index (-1 = full frame)
  task automatic run_frame(input int w, input int kind, input int gap,
                           input int stop_at, input bit rst_at_stop);
    int val, g;
    logic signed [15:0] v16;
    mw       = w;
    map_size = 9'(w);
    for (int idx = 0; idx < w * w; idx++) begin
      if (idx == stop_at) break;
      case (kind)
        0: val = idx + 1;
        1: begin
          v16 = 16'($urandom);
          val = int'(v16);
        end
        default: begin
          case (idx)
            0: val = -5;
            1: val = -1;
            2: val = -3;
            default: val = -7;
          endcase
        end
      endcase
      vals[idx] = val;
      send(16'(val), 1'b1, 1'b1);
      model_accept(idx);
      if (kind == 1 && idx == 1) map_size = 9'($urandom_range(0, 20));
      g = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (g) send(16'($urandom), 1'b0, 1'b1);
    end
    if (rst_at_stop) begin
      send(16'sd0, 1'b0, 1'b0);
      sys_rst = 1'b1;
      #1;
      check("rst_po_data", int'(po_data), 0);
      check("rst_po_data_valid", int'(po_data_valid), 0);
      check("rst_po_frame_done", int'(po_frame_done), 0);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
    end
    repeat (3) send(16'sd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst        = 1'b1;
    map_size       = '0;
    pi_data        = '0;
    pi_data_valid  = 1'b0;
    pi_frame_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("init_po_data", int'(po_data), 0);
    check("init_po_data_valid", int'(po_data_valid), 0);
    check("init_po_frame_done", int'(po_frame_done), 0);
    sys_rst = 1'b0;

    run_frame(4, 0, 0, -1, 1'b0);   // 6,8,14,16
    run_frame(2, 2, 0, -1, 1'b0);   // -1
    run_frame(5, 0, 0, -1, 1'b0);   // 7,9,17,19
    run_frame(4, 0, 1, -1, 1'b0);   // gaps
    run_frame(4, 0, 0, 5, 1'b0);    // abort before any window completes
    run_frame(4, 0, 0, -1, 1'b0);
    run_frame(4, 0, 0, 10, 1'b1);   // reset mid-frame
    run_frame(4, 0, 0, -1, 1'b0);
    run_frame(1, 1, 0, -1, 1'b0);   // map_size < 2: sample dropped
    run_frame(3, 0, 0, -1, 1'b0);   // single output, odd width
    for (int t = 0; t < 12; t++) begin
      run_frame(int'($urandom_range(2, 12)), 1, 2, -1, 1'b0);
    end
    run_frame(8, 1, 2, 20, 1'b0);   // random abort
    run_frame(6, 1, 0, -1, 1'b0);

    repeat (4) send(16'sd0, 1'b0, 1'b0);
    check("leftover_outputs", exp_q.size(), 0);
    check("leftover_done", done_q.size(), 0);
    check("monitor_saw_outputs", int'(m_chk > 40), 1);

    $display("Result: errors=%0d of %0d checks", d_err + m_err, d_chk + m_chk);
    $finish;
  end

endmodule
